// File: rtl/gemips_pkg.sv
// Shared pipeline constants: memory-op encoding and default datapath widths.
package gemips_pkg;

    localparam int MEM_OP_W = 8;
    localparam logic [MEM_OP_W-1:0] MEM_NOP = 8'h00;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RADDR_W = 5;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: payload register plus valid bit, with load and
// clear enables (clear wins) and asynchronous active-low reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            q   <= d;
            vld <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. ex_ready depends only on registered skid state.
module ex_mem_pipe
    import gemips_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int OP_W    = MEM_OP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_we,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [OP_W-1:0]    ex_mem_op,
    input  logic [DATA_W-1:0]  ex_mem_addr,
    input  logic [DATA_W-1:0]  ex_mem_data,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               mem_we,
    output logic [RADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [OP_W-1:0]    mem_mem_op,
    output logic [DATA_W-1:0]  mem_mem_addr,
    output logic [DATA_W-1:0]  mem_mem_data
);

    localparam int PL_W = 1 + RADDR_W + OP_W + 3 * DATA_W;

    logic [PL_W-1:0] ex_pl;
    logic [PL_W-1:0] main_d;
    logic [PL_W-1:0] main_q;
    logic [PL_W-1:0] skid_q;
    logic            main_vld;
    logic            skid_vld;
    logic            main_load;
    logic            main_clear;
    logic            skid_load;
    logic            skid_clear;
    logic            accept;
    logic            emit;
    logic            main_free;
    logic            main_we;
    logic [OP_W-1:0] main_op;

    assign ex_pl = {ex_we, ex_waddr, ex_wdata, ex_mem_op, ex_mem_addr, ex_mem_data};

    assign ex_ready  = !skid_vld;
    assign accept    = ex_valid && ex_ready && !flush;
    assign emit      = main_vld && mem_ready;
    assign main_free = !main_vld || emit;

    // Skid is always older than any new input, so it refills main first.
    assign main_d     = skid_vld ? skid_q : ex_pl;
    assign main_load  = !flush && main_free && (skid_vld || accept);
    assign main_clear = flush || (main_free && !skid_vld && !accept);
    assign skid_load  = !flush && accept && !main_free;
    assign skid_clear = flush || (main_free && skid_vld);

    pipe_slot #(.W(PL_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .vld   (main_vld)
    );

    pipe_slot #(.W(PL_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (ex_pl),
        .q     (skid_q),
        .vld   (skid_vld)
    );

    assign {main_we, mem_waddr, mem_wdata, main_op, mem_mem_addr, mem_mem_data} = main_q;

    // Bubbles carry no side effect even if MEM ignores mem_valid.
    assign mem_valid  = main_vld;
    assign mem_we     = main_vld && main_we;
    assign mem_mem_op = main_vld ? main_op : OP_W'(MEM_NOP);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed scenarios plus random traffic, all compared
// against a two-entry FIFO reference model.
module tb_ex_mem_pipe;
    import gemips_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int OP_W    = 8;

    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        logic [OP_W-1:0]    op;
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } bundle_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               ex_valid = 1'b0;
    logic               ex_ready;
    logic               ex_we = 1'b0;
    logic [RADDR_W-1:0] ex_waddr = '0;
    logic [DATA_W-1:0]  ex_wdata = '0;
    logic [OP_W-1:0]    ex_mem_op = '0;
    logic [DATA_W-1:0]  ex_mem_addr = '0;
    logic [DATA_W-1:0]  ex_mem_data = '0;
    logic               mem_valid;
    logic               mem_ready = 1'b0;
    logic               mem_we;
    logic [RADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [OP_W-1:0]    mem_mem_op;
    logic [DATA_W-1:0]  mem_mem_addr;
    logic [DATA_W-1:0]  mem_mem_data;

    bundle_t held[$];
    bundle_t emitted[$];
    int      n_chk  = 0;
    int      n_fail = 0;

    ex_mem_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .OP_W(OP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_we        (ex_we),
        .ex_waddr     (ex_waddr),
        .ex_wdata     (ex_wdata),
        .ex_mem_op    (ex_mem_op),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_data  (ex_mem_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_mem_op   (mem_mem_op),
        .mem_mem_addr (mem_mem_addr),
        .mem_mem_data (mem_mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input int wa, input int wd);
        bundle_t b;
        b.we    = 1'b1;
        b.waddr = RADDR_W'(wa);
        b.wdata = DATA_W'(wd);
        b.op    = 8'h03;
        b.addr  = $urandom;
        b.data  = $urandom;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b.we    = 1'($urandom);
        b.waddr = RADDR_W'($urandom);
        b.wdata = $urandom;
        b.op    = OP_W'($urandom);
        b.addr  = $urandom;
        b.data  = $urandom;
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        bundle_t obs;
        obs = {mem_we, mem_waddr, mem_wdata, mem_mem_op, mem_mem_addr, mem_mem_data};
        chk({tag, ".ex_ready"}, ex_ready, held.size() < 2);
        chk({tag, ".mem_valid"}, mem_valid, held.size() != 0);
        if (held.size() != 0) begin
            chk({tag, ".bundle"}, obs, held[0]);
        end else begin
            chk({tag, ".bubble_we"}, mem_we, 1'b0);
            chk({tag, ".bubble_op"}, mem_mem_op, MEM_NOP);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".valid"}, mem_valid, 1'b0);
        chk({tag, ".ex_ready"}, ex_ready, 1'b1);
        chk({tag, ".all_out"},
            {mem_we, mem_waddr, mem_wdata, mem_mem_op, mem_mem_addr, mem_mem_data}, '0);
    endtask

    // One clock: drive inputs, advance the FIFO model at the edge, check at negedge.
    task automatic cyc(input logic v, input bundle_t b, input logic mr, input logic fl);
        logic acc;
        logic em;
        ex_valid    = v;
        ex_we       = b.we;
        ex_waddr    = b.waddr;
        ex_wdata    = b.wdata;
        ex_mem_op   = b.op;
        ex_mem_addr = b.addr;
        ex_mem_data = b.data;
        mem_ready   = mr;
        flush       = fl;
        acc = v && (held.size() < 2) && !fl;
        em  = (held.size() != 0) && mr;
        @(posedge clk);
        if (em) emitted.push_back(held.pop_front());
        if (fl) held.delete();
        else if (acc) held.push_back(b);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    initial begin
        bundle_t idle;
        idle = '0;

        // Reset with inputs active: must be ignored.
        ex_valid = 1'b1;
        ex_waddr = 5'd31;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        ex_valid = 1'b0;
        rst = 1'b1;
        cyc(0, idle, 1, 0);

        // Streaming at full throughput.
        emitted.delete();
        for (int i = 1; i <= 3; i++) begin
            cyc(1, mk(i, 'hA0 + i), 1, 0);
            chk("stream.waddr", mem_waddr, RADDR_W'(i));
            chk("stream.wdata", mem_wdata, DATA_W'('hA0 + i));
        end
        cyc(0, idle, 1, 0);
        chk("stream.count", emitted.size(), 3);

        // Stall absorption.
        emitted.delete();
        cyc(1, mk(4, 'hB4), 1, 0);
        cyc(1, mk(5, 'hB5), 0, 0);
        chk("stall.ex_ready_low", ex_ready, 1'b0);
        cyc(1, mk(6, 'hB6), 0, 0);
        chk("stall.main_holds_4", mem_waddr, RADDR_W'(4));
        cyc(1, mk(6, 'hB6), 1, 0);
        cyc(1, mk(6, 'hB6), 1, 0);
        cyc(0, idle, 1, 0);
        chk("stall.count", emitted.size(), 3);
        if (emitted.size() == 3) begin
            chk("stall.order0", emitted[0].waddr, RADDR_W'(4));
            chk("stall.order1", emitted[1].waddr, RADDR_W'(5));
            chk("stall.order2", emitted[2].waddr, RADDR_W'(6));
        end

        // Flush with both slots full while offering a new bundle.
        emitted.delete();
        cyc(1, mk(7, 'hC7), 0, 0);
        cyc(1, mk(8, 'hC8), 0, 0);
        cyc(1, mk(9, 'hC9), 0, 1);
        chk("flush.valid", mem_valid, 1'b0);
        chk("flush.we", mem_we, 1'b0);
        chk("flush.op", mem_mem_op, MEM_NOP);
        repeat (3) cyc(0, idle, 1, 0);
        chk("flush.nothing_emitted", emitted.size(), 0);

        // Flush coinciding with an emit.
        cyc(1, mk(10, 'hDA), 1, 0);
        emitted.delete();
        cyc(0, idle, 1, 1);
        repeat (3) cyc(0, idle, 1, 0);
        chk("flush_emit.count", emitted.size(), 1);
        if (emitted.size() == 1) chk("flush_emit.waddr", emitted[0].waddr, RADDR_W'(10));

        // Asynchronous reset mid-stream with both slots held.
        cyc(1, mk(11, 'hE1), 0, 0);
        cyc(1, mk(12, 'hE2), 0, 0);
        #2;
        rst = 1'b0;
        #1;
        held.delete();
        check_reset_state("async_reset");
        ex_valid = 1'b1;
        @(negedge clk);
        check_reset_state("reset_hold");
        ex_valid = 1'b0;
        rst = 1'b1;
        cyc(0, idle, 1, 0);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom % 4) != 0, rnd_bundle(), ($urandom % 3) != 0, ($urandom % 32) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It sits between the execute stage and the memory stage. It carries the register-writeback fields and the load/store request fields. It lets MEM stall without a combinational ready path back into EX, and lets hazard/exception logic kill in-flight work.

## Interface
- `DATA_W`, 32: width of `wdata`, `mem_addr`, `mem_data`.
- `RADDR_W`, 5: register-file address width.
- `OP_W`, 8: memory-op code width; must match `MEM_OP_W` in the package.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all held entries.
- `ex_valid` in 1: EX presents a valid bundle.
- `ex_ready` out 1: block can accept a bundle this cycle.
- `ex_we`, `ex_waddr`[RADDR_W], `ex_wdata`[DATA_W] in: writeback fields.
- `ex_mem_op`[OP_W], `ex_mem_addr`[DATA_W], `ex_mem_data`[DATA_W] in: memory request fields.
- `mem_valid` out 1: output bundle valid.
- `mem_ready` in 1: MEM consumes the bundle this cycle.
- `mem_we`, `mem_waddr`, `mem_wdata`, `mem_mem_op`, `mem_mem_addr`, `mem_mem_data` out: registered bundle (same widths as the inputs).

## Operation
- Storage is two slots: the main slot, which drives the outputs, and the skid slot. Each slot has a valid bit.
- Accept condition: `ex_valid && ex_ready && !flush`.
- Emit condition: `mem_valid && mem_ready`.
- `ex_ready` is the inverse of the skid valid bit. It is a register output with no combinational path from `mem_ready`.
- Main slot update, when it is empty or emitting:
  - If the skid slot is valid, the skid contents move to main and the skid clears.
  - Otherwise, an accepted input loads main.
  - Otherwise, main becomes invalid.
- Skid slot load: an accepted input that cannot enter main (main full and not emitting) goes to the skid slot.
- Ordering: strictly FIFO. Bundles are never dropped or duplicated except by flush.
- Flush takes priority over every other update:
  - Both valid bits clear next cycle.
  - Any input offered in the flush cycle is discarded.
  - A bundle emitted in the flush cycle still counts as consumed by MEM.
- Bubble gating: while `mem_valid` = 0, `mem_we` reads 0 and `mem_mem_op` reads `MEM_NOP`. MEM may ignore `mem_valid` and still see no side effect.
- Payload fields are stored unchanged; no width conversion is performed.

## Timing
- Reset values (all outputs, while `rst` = 0):
  - `mem_valid`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0.
  - `mem_mem_op`=`MEM_NOP`, `mem_mem_addr`=0, `mem_mem_data`=0.
  - Skid slot invalid, so `ex_ready`=1.
- Inputs are ignored while `rst` = 0. Deassertion takes effect at the next clock edge.
- Reset asserted mid-operation: both entries are lost immediately (asynchronous).
- Latency: an accepted bundle appears on `mem_*` the cycle after acceptance when main is free; otherwise it waits behind the main entry.
- Throughput: one bundle per cycle while `mem_ready`=1.
- Back-pressure:
  - With `mem_ready`=0 and main full, exactly one more bundle is absorbed (into skid).
  - `ex_ready` drops the following cycle.
  - When `mem_ready` returns, `ex_ready` rises one cycle after skid drains.
- Simultaneous events:
  - Accept + emit with skid empty: input goes directly to main.
  - Flush + accept: flush wins.
  - Flush + emit: output consumed, slots cleared.

## Structure
- Shared package `gemips_pkg`: `MEM_OP_W`=8, `MEM_NOP`=8'h00, and the default widths.
- One natural sub-module, `pipe_slot`: a parameterised payload+valid register with load/clear enables and async active-low reset. It is instantiated twice (main, skid).
- The top level holds only the slot control logic and the bubble gating.
- Target size: 150–250 lines.

## Test plan
- Reset → `mem_valid`=0, `mem_mem_op`=8'h00, `ex_ready`=1. Assert `rst` low mid-stream with two entries held → all outputs zeroed at once, `ex_ready`=1.
- Streaming, with `mem_ready`=1 held: present bundles `ex_waddr`=1,2,3 with `ex_wdata`=0xA1,0xA2,0xA3 on consecutive cycles → same sequence on `mem_*` one cycle later, no gaps.
- Stall absorption:
  - With main holding waddr=4, drop `mem_ready` and offer waddr=5, then waddr=6.
  - Required: 5 goes to skid and `ex_ready`=0 next cycle; 6 is not accepted.
  - Release `mem_ready` → output order 4, 5, 6.
- Flush:
  - With both slots full (waddr 7, 8), assert `flush` for one cycle while offering waddr=9.
  - Required: next cycle `mem_valid`=0, `mem_we`=0, `mem_mem_op`=`MEM_NOP`; 9 is never emitted.
- Flush + emit:
  - Main=waddr 10, `mem_ready`=1, `flush`=1.
  - Required: 10 is seen consumed once; no duplicate of 10 after flush.
- Random valid/ready/flush with a scoreboard over 10k cycles:
  - No loss or reordering outside flush.
  - No output change while `mem_valid && !mem_ready`.
